// File: rtl/fifo_write_side.sv
// Write-clock-domain half of a dual-clock FIFO: write pointer, Gray export, read-pointer sync, full.
// Define FIFO_ALMOST_FULL_EN to add the registered afull flag and its fill-level logic.
module fifo_write_side #(
    parameter int unsigned WIDTH     = 4
`ifdef FIFO_ALMOST_FULL_EN
    ,
    parameter int unsigned AFULL_LVL = 2
`endif
) (
    input  logic             clk1,
    input  logic             rst1,
    input  logic             count1,
    input  logic [WIDTH-1:0] pointerinw,
    output logic [WIDTH-1:0] pointeroutw,
    output logic             full,
    output logic [WIDTH-2:0] wadd,
`ifdef FIFO_ALMOST_FULL_EN
    output logic             afull,
`endif
    output logic             wen
);

    logic [WIDTH-1:0] wbin_q, wbin_d;
    logic [WIDTH-1:0] wgray_q, wgray_d;
    logic [WIDTH-1:0] rsync1_q, rsync2_q;
    logic [WIDTH-1:0] full_cmp;
    logic [WIDTH-2:0] wadd_q, wadd_d;
    logic             full_q, full_d;

    assign wen = count1 & ~full_q & ~rst1;

    always_comb begin
        wbin_d   = wen ? wbin_q + WIDTH'(1) : wbin_q;
        wgray_d  = wbin_d ^ (wbin_d >> 1);
        wadd_d   = wbin_d[WIDTH-2:0];
        // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
        full_cmp = {~rsync2_q[WIDTH-1:WIDTH-2], rsync2_q[WIDTH-3:0]};
        full_d   = (wgray_d == full_cmp);
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            rsync1_q <= '0;
            rsync2_q <= '0;
            wadd_q   <= '0;
            full_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            rsync1_q <= pointerinw;
            rsync2_q <= rsync1_q;
            wadd_q   <= wadd_d;
            full_q   <= full_d;
        end
    end

    assign pointeroutw = wgray_q;
    assign wadd        = wadd_q;
    assign full        = full_q;

`ifdef FIFO_ALMOST_FULL_EN
    localparam int unsigned      Depth       = 1 << (WIDTH - 1);
    localparam logic [WIDTH-1:0] AfullThresh = WIDTH'(Depth - AFULL_LVL);

    logic [WIDTH-1:0] rbin;
    logic [WIDTH-1:0] fill;
    logic             afull_q, afull_d;

    always_comb begin
        // Each binary bit is the XOR of all Gray bits from the MSB down to it.
        for (int i = 0; i < WIDTH; i++) begin
            rbin[i] = ^(rsync2_q >> i);
        end
        fill    = wbin_d - rbin;
        afull_d = (fill >= AfullThresh);
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign afull = afull_q;
`endif

endmodule

// File: tb/tb_fifo_write_side.sv
// Bench for fifo_write_side: directed vector table, hand sequences, and random traffic vs an
// occupancy-based model. afull is checked when FIFO_ALMOST_FULL_EN is defined.
module tb_fifo_write_side;

    logic       clk1 = 1'b0;
    logic       rst1;
    logic       count1;
    logic [3:0] pointerinw;
    logic [3:0] pointeroutw;
    logic       full;
    logic [2:0] wadd;
    logic       wen;
`ifdef FIFO_ALMOST_FULL_EN
    logic       afull;
`endif

    int tests = 0;
    int fails = 0;

    fifo_write_side #(.WIDTH(4)) dut (
        .clk1       (clk1),
        .rst1       (rst1),
        .count1     (count1),
        .pointerinw (pointerinw),
        .pointeroutw(pointeroutw),
        .full       (full),
        .wadd       (wadd),
`ifdef FIFO_ALMOST_FULL_EN
        .afull      (afull),
`endif
        .wen        (wen)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       req;
        logic [3:0] rptr;
        logic       exp_wen;
        logic [2:0] exp_wadd_pre;
        logic [3:0] exp_ptr;
        logic [2:0] exp_wadd;
        logic       exp_full;
        logic       exp_afull;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic r, q, input logic [3:0] rp, input logic ew,
                                input logic [2:0] wp, input logic [3:0] p, input logic [2:0] wa,
                                input logic f, af);
        vec_t v;
        v.rst = r; v.req = q; v.rptr = rp; v.exp_wen = ew; v.exp_wadd_pre = wp;
        v.exp_ptr = p; v.exp_wadd = wa; v.exp_full = f; v.exp_afull = af;
        return v;
    endfunction

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    // Model: write count, and the read count as seen after each of the two sync stages.
    int m_w, m_s1, m_s2;
    bit m_full, m_afull;

    task automatic mstep(input bit r, input bit q, input int rb);
        bit ew;
        int wn, occ;
        rst1 = r; count1 = q; pointerinw = gray(rb);
        ew = q && !m_full && !r;
        #1;
        check("m_wen", wen, ew);
        @(posedge clk1);
        #1;
        if (r) begin
            m_w = 0; m_s1 = 0; m_s2 = 0; m_full = 0; m_afull = 0;
        end else begin
            wn = (m_w + int'(ew)) % 16;
            occ = (wn - m_s2 + 16) % 16;
            m_full = (occ == 8);
            m_afull = (occ >= 6);
            m_w = wn;
            m_s2 = m_s1;
            m_s1 = rb % 16;
        end
        check("m_ptr", pointeroutw, gray(m_w));
        check("m_wadd", wadd, m_w % 8);
        check("m_full", full, m_full);
`ifdef FIFO_ALMOST_FULL_EN
        check("m_afull", afull, m_afull);
`endif
    endtask

    initial begin
        bit saw_wrap, any_full, r, q;
        int n, rb, m_r;
        logic [3:0] prev;

        vecs[0]  = mk(1, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        vecs[1]  = mk(1, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        vecs[2]  = mk(0, 1, 4'b0000, 1, 0, 4'b0001, 1, 0, 0);
        vecs[3]  = mk(0, 1, 4'b0000, 1, 1, 4'b0011, 2, 0, 0);
        vecs[4]  = mk(0, 1, 4'b0000, 1, 2, 4'b0010, 3, 0, 0);
        vecs[5]  = mk(0, 1, 4'b0000, 1, 3, 4'b0110, 4, 0, 0);
        vecs[6]  = mk(0, 1, 4'b0000, 1, 4, 4'b0111, 5, 0, 0);
        vecs[7]  = mk(0, 1, 4'b0000, 1, 5, 4'b0101, 6, 0, 1);
        vecs[8]  = mk(0, 1, 4'b0000, 1, 6, 4'b0100, 7, 0, 1);
        vecs[9]  = mk(0, 1, 4'b0000, 1, 7, 4'b1100, 0, 1, 1);
        vecs[10] = mk(0, 1, 4'b0000, 0, 0, 4'b1100, 0, 1, 1);
        vecs[11] = mk(0, 0, 4'b0001, 0, 0, 4'b1100, 0, 1, 1);
        vecs[12] = mk(0, 0, 4'b0001, 0, 0, 4'b1100, 0, 1, 1);
        vecs[13] = mk(0, 0, 4'b0001, 0, 0, 4'b1100, 0, 0, 1);
        vecs[14] = mk(0, 1, 4'b0001, 1, 0, 4'b1101, 1, 1, 1);

        for (int i = 0; i < 15; i++) begin
            rst1 = vecs[i].rst; count1 = vecs[i].req; pointerinw = vecs[i].rptr;
            #1;
            check($sformatf("vec%0d wen", i), wen, vecs[i].exp_wen);
            if (vecs[i].exp_wen) check($sformatf("vec%0d wadd_pre", i), wadd, vecs[i].exp_wadd_pre);
            @(posedge clk1);
            #1;
            check($sformatf("vec%0d ptr", i), pointeroutw, vecs[i].exp_ptr);
            check($sformatf("vec%0d wadd", i), wadd, vecs[i].exp_wadd);
            check($sformatf("vec%0d full", i), full, vecs[i].exp_full);
`ifdef FIFO_ALMOST_FULL_EN
            check($sformatf("vec%0d afull", i), afull, vecs[i].exp_afull);
`endif
        end

        // Reset in the middle of operation.
        m_w = 0; m_s1 = 0; m_s2 = 0; m_full = 0; m_afull = 0;
        mstep(1, 0, 0);
        for (int i = 0; i < 5; i++) mstep(0, 1, 0);
        check("midrst ptr5", pointeroutw, 4'b0111);
        mstep(1, 1, 0);
        mstep(1, 1, 0);
        check("midrst ptr", pointeroutw, 4'b0000);

        // Wrap with the reader two writes behind.
        mstep(1, 0, 0);
        saw_wrap = 0; any_full = 0; n = 0;
        for (int i = 0; i < 20; i++) begin
            prev = pointeroutw;
            rb = (n >= 2) ? n - 2 : 0;
            mstep(0, 1, rb);
            n++;
            if (prev == 4'b1000 && pointeroutw == 4'b0000 && wadd == 3'd0) saw_wrap = 1;
            if (full) any_full = 1;
        end
        check("wrap seen", saw_wrap, 1);
        check("wrap no full", any_full, 0);

        // Random traffic; the reader only consumes entries actually written.
        mstep(1, 0, 0);
        m_r = 0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            q = ($urandom_range(0, 3) != 0);
            if (r) m_r = 0;
            else if (((m_w - m_r + 16) % 16) > 0 && $urandom_range(0, 99) < 40)
                m_r = (m_r + 1) % 16;
            mstep(r, q, m_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_write_side.md
Name: fifo_write_side

Overview:
Write-clock-domain half of the dual-clock FIFO. It pairs with the read-domain half, which consumes its Gray pointer.
- Accepts write requests and generates the RAM write enable and write address.
- Maintains the binary and Gray write pointers and exports the Gray pointer to the read domain.
- Double-flop synchronizes the incoming read Gray pointer and produces a registered full flag.
- Sits between the producer and the shared dual-port storage.

Parameters:
- WIDTH, 4, pointer width in bits. Address width is WIDTH-1; depth is 2^(WIDTH-1) entries (8 at default).
- AFULL_LVL, 2, free-slot threshold for the almost-full flag (used only when FIFO_ALMOST_FULL_EN is defined). Legal range 1 to depth-1.

Ports:
- clk1  in  1  write-domain clock, rising edge.
- rst1  in  1  synchronous active-high reset.
- count1  in  1  write request from the producer.
- pointerinw  in  WIDTH  read-domain Gray pointer, asynchronous to clk1.
- pointeroutw  out  WIDTH  registered Gray write pointer to the read domain.
- full  out  1  registered full flag.
- wadd  out  WIDTH-1  registered RAM write address.
- wen  out  1  RAM write strobe; the RAM captures data at wadd on the same clk1 edge.
- afull  out  1  registered almost-full flag (present only with FIFO_ALMOST_FULL_EN).

Behaviour:
- Clock and reset: one clock, clk1. Reset rst1 is synchronous and active-high.
- Reset: on a clk1 edge with rst1=1, clear the binary pointer, Gray pointer, both sync stages, full, afull and wadd to 0.
- wen is forced to 0 while rst1=1.
- A reset mid-operation discards all contents. The read half must be reset in the same window.
- Synchronizer: pointerinw passes through two clk1 flops (rsync). No logic sits between the stages.
- Write accept: wen = count1 & ~full & ~rst1 (combinational).
- On an accepted write:
  - wbin <= wbin+1, mod 2^WIDTH.
  - pointeroutw <= gray(wbin+1), where gray(x) = x ^ (x>>1).
  - wadd <= low WIDTH-1 bits of wbin+1.
- With count1=1 and full=1: the request is dropped. No pointer or address change; wen=0. No overflow error signal.
- Latency: wadd and pointeroutw update on the edge that accepts the write, i.e. one edge after wen is sampled high.
- pointeroutw is taken straight from a register so it is glitch-free across domains. Exactly one bit changes per increment.
- Full flag:
  - gnext = gray of next wbin (wbin+1 if accepting, else wbin).
  - full <= (gnext == {~rsync[WIDTH-1:WIDTH-2], rsync[WIDTH-3:0]}).
  - full rises on the edge that accepts the depth-th outstanding write.
  - full falls no earlier than 3 clk1 edges after pointerinw advances (2 sync stages + 1 flag register). This is pessimistic, never optimistic.
- Wrap-around: wbin goes from 2^WIDTH-1 to 0, Gray from 1000 to 0000 at WIDTH=4, and wadd from depth-1 to 0. No special-case logic.
- Simultaneous events:
  - rst1 overrides count1.
  - A read advancing on the same edge as a write becomes visible to full only after synchronization.
- Fill level (for afull):
  - rbin = Gray-to-binary(rsync), a prefix XOR from the MSB.
  - fill = (next wbin − rbin) mod 2^WIDTH.

Optional Feature:
Macro: FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds the afull port and the Gray-to-binary and fill logic.
  - afull <= (fill >= depth − AFULL_LVL), registered, reset 0.
  - afull is asserted whenever full is asserted.
- Not defined: the afull port, the Gray-to-binary logic and the fill logic are absent. All other behaviour is unchanged.

Test Plan:
1. Reset: rst1=1 for 2 edges with count1=1 → pointeroutw=0000, wadd=0, full=0, wen=0, afull=0.
2. Fill: pointerinw=0000, count1=1 for 9 edges →
   - wadd steps 0..7, then wraps to 0.
   - pointeroutw steps 0001,0011,0010,0110,0111,0101,0100,1100.
   - full=1 after the 8th accept.
   - 9th request: wen=0, pointeroutw holds 1100.
3. Release: from the full state, set pointerinw=0001 → full=0 on the 3rd clk1 edge. The next write has wen=1 at wadd=0, and pointeroutw becomes 1101.
4. Wrap: 20 writes with pointerinw tracking pointeroutw, two writes behind → pointeroutw passes 1000→0000, wadd 7→0, full never asserts.
5. Reset mid-op: after 5 writes (pointeroutw=0111), assert rst1 with count1=1 → next edge pointeroutw=0000, wadd=0, full=0; wen=0 throughout reset.
6. With FIFO_ALMOST_FULL_EN and AFULL_LVL=2: pointerinw=0000, 6 writes → afull=1 at fill 6 while full=0; 2 more writes → full=1, afull=1.
